// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 codes, FSM state type and access decode helpers for dmem_port
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Access width in bytes; bit 2 of funct3 only selects sign handling.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: is_legal = 1'b1;
      F3_BU, F3_HU:     is_legal = !we;
      default:          is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - combinational load formatter: raw little-endian bytes to extended result
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  // Select the valid low bytes and sign- or zero-extend them.
  always_comb begin
    rdata = 32'h0;
    case (funct3)
      F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
      F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
      F3_W:    rdata = raw;
      F3_BU:   rdata = {24'h0, raw[7:0]};
      F3_HU:   rdata = {16'h0, raw[15:0]};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - byte-addressed data memory with valid/ready request/response; option DMEM_MISALIGNED_EN
module dmem_port
  import dmem_pkg::*;
#(
  parameter int SZ      = 4096,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (SZ > 1) ? $clog2(SZ) : 1;

  logic [7:0] mem [SZ];

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic [2:0]  nbytes;
  logic        legal;
  logic        misaligned;
  logic [32:0] end_addr;
  logic        out_of_range;
  logic        dec_err;
  logic [AW-1:0] idx [4];
  logic [31:0] raw_bytes;
  logic [31:0] fmt_rdata;

  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Decode the request: width, legality, alignment and range (33-bit so the end address cannot wrap).
  always_comb begin
    nbytes       = size_bytes(req_funct3);
    legal        = is_legal(req_we, req_funct3);
`ifdef DMEM_MISALIGNED_EN
    misaligned   = 1'b0;
`else
    misaligned   = ((nbytes == 3'd2) && req_addr[0]) ||
                   ((nbytes == 3'd4) && (req_addr[1:0] != 2'b00));
`endif
    end_addr     = {1'b0, req_addr} + {30'h0, nbytes};
    out_of_range = end_addr > 33'(SZ);
    dec_err      = !legal || misaligned || out_of_range;
  end

  // Gather the addressed bytes individually so misaligned accesses need no extra path.
  always_comb begin
    raw_bytes = 32'h0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = req_addr[AW-1:0] + AW'(i);
      if (3'(i) < nbytes) raw_bytes[8*i +: 8] = mem[idx[i]];
    end
  end

  dmem_lane_fmt u_fmt (
    .raw    (raw_bytes),
    .funct3 (req_funct3),
    .rdata  (fmt_rdata)
  );

  // Stores commit at the accept edge; memory is never reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !dec_err) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < nbytes) mem[idx[i]] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Next-state and response capture: accept -> (WAIT countdown) -> RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = (dec_err || req_we) ? 32'h0 : fmt_rdata;
          err_d   = dec_err;
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - self-checking bench for dmem_port (SZ=64, LATENCY=3); honours DMEM_MISALIGNED_EN
module tb_dmem_port;

  localparam int SZ  = 64;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 0;

  dmem_port #(.SZ(SZ), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: byte array plus an outstanding-response countdown.
  logic [7:0]  m_mem [SZ];
  bit          m_pending = 0;
  int          m_wait = 0;
  logic [31:0] m_rdata = 0;
  logic        m_err = 0;

  task automatic model_accept();
    int nb;
    bit legal, mis, oor;
    logic [31:0] v;
    legal = (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) &&
            !(req_we && (req_funct3 == 3'd4 || req_funct3 == 3'd5));
    nb = (req_funct3 == 3'd0 || req_funct3 == 3'd4) ? 1 :
         (req_funct3 == 3'd1 || req_funct3 == 3'd5) ? 2 : 4;
    mis = 0;
`ifndef DMEM_MISALIGNED_EN
    mis = (req_addr % nb) != 0;
`endif
    oor = (longint'(req_addr) + nb) > SZ;
    if (!legal || mis || oor) begin
      m_rdata = 0;
      m_err = 1;
    end else if (req_we) begin
      for (int k = 0; k < nb; k++) m_mem[req_addr + k] = 8'(req_wdata >> (8 * k));
      m_rdata = 0;
      m_err = 0;
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v = v | (32'(m_mem[req_addr + k]) << (8 * k));
      if (req_funct3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (req_funct3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      m_rdata = v;
      m_err = 0;
    end
    m_pending = 1;
    m_wait = LAT - 1;
  endtask

  // Model advances on the same edges the DUT does, reading only bench-driven inputs.
  always @(posedge clk) begin
    if (!rst_n) m_pending = 0;
    else if (m_pending) begin
      if (m_wait > 0) m_wait--;
      else if (rsp_ready) m_pending = 0;
    end else if (req_valid) model_accept();
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, rst_n && !m_pending);
      chk("rsp_valid", rsp_valid, m_pending && m_wait == 0);
      if (m_pending && m_wait == 0) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end else if (!m_pending) begin
        chk("idle_rdata", rsp_rdata, 0);
        chk("idle_err", rsp_err, 0);
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, input bit do_rst,
                        output logic [31:0] rd, output logic er);
    bit acc;
    int n;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1;
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin
      if (req_ready) acc = 1;
      @(posedge clk); #1;
    end
    chk("accept", 32'(acc), 1);
    req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, LAT);
    rd = rsp_rdata;
    er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_req_ready", req_ready, 0);
    end
    if (do_rst) begin
      rst_n = 0;
      @(posedge clk); #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      rst_n = 1;
      #1;
      chk("post_rst_ready", req_ready, 1);
    end else begin
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
    end
  endtask

  task automatic op(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic er;
    do_req(we, f3, addr, wd, 0, 0, rd, er);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, er, exp_err);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    rst_n = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk("reset_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_err", rsp_err, 0);
    chk("reset_req_ready", req_ready, 0);
    rst_n = 1;
    #1;
    chk("idle_req_ready", req_ready, 1);

    op("sw10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0);
    op("lw10",  0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0);
    op("lb13",  0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0);
    op("lbu13", 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0);
    op("lh12",  0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0);
    op("lhu10", 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0);
    op("sw14",  1, 3'b010, 32'h14, 32'h11223344, 32'h0,        0);
`ifdef DMEM_MISALIGNED_EN
    op("lw11",  0, 3'b010, 32'h11, 32'h0,        32'h44DEADBE, 0);
`else
    op("lw11",  0, 3'b010, 32'h11, 32'h0,        32'h0,        1);
`endif
    op("sb11",  1, 3'b000, 32'h11, 32'h12345677, 32'h0,        0);
    op("lw10b", 0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0);
    op("sw00",  1, 3'b010, 32'h0,  32'hCAFEF00D, 32'h0,        0);
    op("lw_sz2", 0, 3'b010, SZ - 2, 32'h0,       32'h0,        1);
    op("sw_sz", 1, 3'b010, SZ,     32'h55555555, 32'h0,        1);
    op("f3_011", 0, 3'b011, 32'h0, 32'h0,        32'h0,        1);
    op("sbu",   1, 3'b100, 32'h0,  32'hFFFFFFFF, 32'h0,        1);
    op("lw00",  0, 3'b010, 32'h0,  32'h0,        32'hCAFEF00D, 0);
    op("sb3f",  1, 3'b000, SZ - 1, 32'h00000080, 32'h0,        0);
    op("lb3f",  0, 3'b000, SZ - 1, 32'h0,        32'hFFFFFF80, 0);
    op("lh3f",  0, 3'b001, SZ - 1, 32'h0,        32'h0,        1);

    do_req(0, 3'b010, 32'h10, 32'h0, 5, 1, rd, er);
    chk("held_rdata", rd, 32'hDEAD77EF);
    chk("held_err", er, 0);
    op("lw10c", 0, 3'b010, 32'h10, 32'h0,        32'hDEAD77EF, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
